icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the fetch stage and the tagged instruction memory bus. It answers the fetch stage's `proc2Icache_addr` with a 64-bit block and `Icache2proc_data_valid`, with zero latency on a hit. On a miss it issues one `BUS_LOAD`, tracks the returned transaction tag, fills the line and forwards the data. At most one miss is outstanding at a time.

## Interface
Parameters:
- `NUM_LINES`, default 32: number of 8-byte lines; power of two. `IDX_W = $clog2(NUM_LINES)`.
- `MEM_TAG_W`, default 4: width of the memory transaction tag. Tag 0 means "none".

Ports:
- `clock`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset; asserted when 0
- `proc2Icache_addr`  input  `XLEN`  fetch byte address; bits [2:0] ignored
- `Icache2proc_data`  output  64  block containing the requested address
- `Icache2proc_data_valid`  output  1  `Icache2proc_data` is valid this cycle
- `proc2Imem_command`  output  2  `BUS_NONE`=0 or `BUS_LOAD`=1
- `proc2Imem_addr`  output  `XLEN`  block-aligned miss address (low 3 bits 0)
- `Imem2proc_response`  input  `MEM_TAG_W`  nonzero = request accepted, with that tag
- `Imem2proc_data`  input  64  returning block
- `Imem2proc_tag`  input  `MEM_TAG_W`  tag of `Imem2proc_data`; 0 = no return

## Operation
- Address split: index = addr[IDX_W+2:3]; tag = addr[`XLEN`-1:IDX_W+3].
- Storage per line: data (64), tag, valid bit.
- Hit = line valid and tags equal. A hit drives data and valid=1 combinationally, in any state.
- States:
  - IDLE: on a miss, drive `BUS_LOAD` with the aligned address in the same cycle. If `Imem2proc_response`≠0, latch that tag and the miss address, then go to WAIT. If it is 0, stay in IDLE and retry next cycle. The retry uses the current address, so an address change before acceptance re-decides hit or miss.
  - WAIT: command = `BUS_NONE`. When `Imem2proc_tag` equals the latched tag (and the latched tag ≠0), write data, tag and valid=1 to the latched index, clear the latched tag, and go to IDLE.
- Forwarding: in the fill cycle, if the current address's block equals the latched block, output `Imem2proc_data` with valid=1.
- Redirects while in WAIT: the fill still completes into the latched line. The new address is served as a hit if it hits; otherwise its miss is issued after the return to IDLE.
- Returns with a non-matching tag, or arriving in IDLE, are ignored.
- When not valid, `Icache2proc_data` = 0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, all valid bits=0, latched tag=0, command=`BUS_NONE`, address=0, data=0, data_valid=0.
- Reset released mid-miss: the outstanding return is ignored and no line is written.
- Hit latency: 0 cycles (combinational).
- Miss latency: fill cycle = cycle with the matching `Imem2proc_tag`, with forwarded data valid in that same cycle. The cache line is valid from the next edge.
- A miss with `Imem2proc_response`≠0 in its first cycle: exactly one cycle of `BUS_LOAD`.
- A fill and a hit on a different line in the same cycle: the hit's data is served and the fill is written. A fill to the same index replaces the line at the edge.

## Configuration
- `ICACHE_STATS_EN` defined: adds outputs `icache_hit_count` and `icache_miss_count`, each 32 bits, reset 0, wrapping.
  - Hit count increments on every cycle with data_valid=1 from a stored line; forwarding cycles are not counted.
  - Miss count increments on every IDLE→WAIT transition.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Cold miss: reset, addr=0x0000_0100, response=3 → command=`BUS_LOAD`, address=0x100, state WAIT. A later tag=3 with data=0xDEAD_BEEF_0123_4567 → data_valid=1 with that data in the same cycle; the next cycle is a hit with the same data and no command.
- Response backpressure: miss with response=0 for 3 cycles, then 2 → `BUS_LOAD` held for 4 cycles with address constant; exactly one WAIT entry.
- Wrong tag: in WAIT (tag 5), returns with tag=4 and tag=0 → ignored, no valid; tag=5 → fill.
- Redirect during WAIT: miss on 0x200 (tag 1), then addr changes to 0x308 → no new command until tag 1 returns and the 0x200 line fills. The next cycle issues `BUS_LOAD` 0x308. A later access to 0x204 hits.
- Conflict: fill 0x100, then fill 0x2100 (same index, NUM_LINES=32) → an access to 0x100 misses again.
- Async reset in WAIT: assert reset mid-cycle → outputs 0 immediately. After release, the matching tag return is ignored and the prior address misses.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with one outstanding tagged miss.
// Optional hit/miss counters are built in when ICACHE_STATS_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module icache_line #(
    parameter int TAG_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [TAG_W-1:0] wtag,
    input  logic [63:0]      wdata,
    output logic             vld,
    output logic [TAG_W-1:0] tag,
    output logic [63:0]      data
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld  <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else if (we) begin
            vld  <= 1'b1;
            tag  <= wtag;
            data <= wdata;
        end
    end
endmodule

module icache #(
    parameter int NUM_LINES = 32,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [`XLEN-1:0]     proc2Icache_addr,
    output logic [63:0]          Icache2proc_data,
    output logic                 Icache2proc_data_valid,
    output logic [1:0]           proc2Imem_command,
    output logic [`XLEN-1:0]     proc2Imem_addr,
    input  logic [MEM_TAG_W-1:0] Imem2proc_response,
    input  logic [63:0]          Imem2proc_data,
    input  logic [MEM_TAG_W-1:0] Imem2proc_tag
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          icache_hit_count,
    output logic [31:0]          icache_miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int BLK_W = `XLEN - 3;
    localparam int TAG_W = BLK_W - IDX_W;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [MEM_TAG_W-1:0]   mem_tag_q, mem_tag_d;
    logic [BLK_W-1:0]       miss_blk_q, miss_blk_d;

    logic [NUM_LINES-1:0]             line_vld;
    logic [NUM_LINES-1:0]             line_we;
    logic [NUM_LINES-1:0][TAG_W-1:0]  line_tag;
    logic [NUM_LINES-1:0][63:0]       line_data;

    logic [BLK_W-1:0] req_blk;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit, fill, fwd;
    logic [1:0]       cmd;
    logic [`XLEN-1:0] maddr;
    logic             unused_addr_bits;

    assign req_blk          = proc2Icache_addr[`XLEN-1:3];
    assign req_idx          = req_blk[IDX_W-1:0];
    assign req_tag          = req_blk[BLK_W-1:IDX_W];
    assign miss_idx         = miss_blk_q[IDX_W-1:0];
    assign miss_tag         = miss_blk_q[BLK_W-1:IDX_W];
    assign unused_addr_bits = ^proc2Icache_addr[2:0];

    genvar g;
    generate
        for (g = 0; g < NUM_LINES; g++) begin : g_line
            icache_line #(.TAG_W(TAG_W)) u_line (
                .clock (clock),
                .reset (reset),
                .we    (line_we[g]),
                .wtag  (miss_tag),
                .wdata (Imem2proc_data),
                .vld   (line_vld[g]),
                .tag   (line_tag[g]),
                .data  (line_data[g])
            );
        end
    endgenerate

    assign hit  = line_vld[req_idx] && (line_tag[req_idx] == req_tag);
    // A zero latched tag means nothing is outstanding, so tag-0 returns never fill.
    assign fill = (state_q == S_WAIT) && (mem_tag_q != '0) && (Imem2proc_tag == mem_tag_q);
    assign fwd  = fill && (req_blk == miss_blk_q);

    always_comb begin
        line_we = '0;
        if (fill) line_we[miss_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        mem_tag_d  = mem_tag_q;
        miss_blk_d = miss_blk_q;
        cmd        = BUS_NONE;
        maddr      = '0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    cmd   = BUS_LOAD;
                    maddr = {req_blk, 3'b000};
                    if (Imem2proc_response != '0) begin
                        mem_tag_d  = Imem2proc_response;
                        miss_blk_d = req_blk;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (fill) begin
                    mem_tag_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_tag_q  <= '0;
            miss_blk_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_tag_q  <= mem_tag_d;
            miss_blk_q <= miss_blk_d;
        end
    end

    // Outputs are forced quiet while reset is held, even though the FSM would otherwise request a load.
    always_comb begin
        Icache2proc_data       = '0;
        Icache2proc_data_valid = 1'b0;
        proc2Imem_command      = BUS_NONE;
        proc2Imem_addr         = '0;
        if (reset) begin
            proc2Imem_command = cmd;
            proc2Imem_addr    = maddr;
            if (hit) begin
                Icache2proc_data       = line_data[req_idx];
                Icache2proc_data_valid = 1'b1;
            end else if (fwd) begin
                Icache2proc_data       = Imem2proc_data;
                Icache2proc_data_valid = 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            icache_hit_count  <= '0;
            icache_miss_count <= '0;
        end else begin
            if (hit) icache_hit_count <= icache_hit_count + 32'd1;
            if (state_q == S_IDLE && state_d == S_WAIT)
                icache_miss_count <= icache_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed table-driven bench for icache: one vector per cycle, plus an async-reset sequence.
module tb_icache;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr  = 32'h100;
    logic [3:0]  resp  = '0;
    logic [3:0]  rtag  = '0;
    logic [63:0] rdata = '0;
    logic [63:0] dout;
    logic        dvld;
    logic [1:0]  cmd;
    logic [31:0] maddr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D5 = 64'hCAFE_F00D_BAAD_C0DE;
    localparam logic [63:0] D6 = 64'h7777_8888_9999_AAAA;

    icache dut (
        .clock                  (clock),
        .reset                  (reset),
        .proc2Icache_addr       (addr),
        .Icache2proc_data       (dout),
        .Icache2proc_data_valid (dvld),
        .proc2Imem_command      (cmd),
        .proc2Imem_addr         (maddr),
        .Imem2proc_response     (resp),
        .Imem2proc_data         (rdata),
        .Imem2proc_tag          (rtag)
`ifdef ICACHE_STATS_EN
        ,
        .icache_hit_count       (hit_cnt),
        .icache_miss_count      (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [63:0] rdata;
        logic        e_vld;
        logic [63:0] e_data;
        logic [1:0]  e_cmd;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t v[26];

    task automatic chk(input string name, input logic ev, input logic [63:0] ed,
                       input logic [1:0] ec, input logic [31:0] ea);
        n_vec++;
        if (dvld !== ev || dout !== ed || cmd !== ec || maddr !== ea) begin
            n_bad++;
            $display("FAIL %s: got vld=%0b data=%h cmd=%0d addr=%h, expected vld=%0b data=%h cmd=%0d addr=%h",
                     name, dvld, dout, cmd, maddr, ev, ed, ec, ea);
        end
    endtask

    initial begin
        //        addr        resp rtag rdata  vld data cmd maddr
        v[0]  = '{32'h100,  4'd3, 4'd0, '0, 1'b0, '0, 2'd1, 32'h100};   // cold miss, accepted
        v[1]  = '{32'h100,  4'd0, 4'd0, '0, 1'b0, '0, 2'd0, 32'h0};
        v[2]  = '{32'h100,  4'd0, 4'd3, D1, 1'b1, D1, 2'd0, 32'h0};     // fill + forward
        v[3]  = '{32'h104,  4'd0, 4'd0, '0, 1'b1, D1, 2'd0, 32'h0};     // hit
        v[4]  = '{32'h2100, 4'd2, 4'd0, '0, 1'b0, '0, 2'd1, 32'h2100};  // conflict miss
        v[5]  = '{32'h2100, 4'd0, 4'd2, D2, 1'b1, D2, 2'd0, 32'h0};
        v[6]  = '{32'h2100, 4'd0, 4'd0, '0, 1'b1, D2, 2'd0, 32'h0};
        v[7]  = '{32'h100,  4'd0, 4'd0, '0, 1'b0, '0, 2'd1, 32'h100};   // evicted, backpressure
        v[8]  = '{32'h100,  4'd0, 4'd0, '0, 1'b0, '0, 2'd1, 32'h100};
        v[9]  = '{32'h100,  4'd0, 4'd0, '0, 1'b0, '0, 2'd1, 32'h100};
        v[10] = '{32'h100,  4'd5, 4'd0, '0, 1'b0, '0, 2'd1, 32'h100};
        v[11] = '{32'h100,  4'd0, 4'd0, '0, 1'b0, '0, 2'd0, 32'h0};
        v[12] = '{32'h100,  4'd0, 4'd4, D3, 1'b0, '0, 2'd0, 32'h0};     // wrong tag
        v[13] = '{32'h100,  4'd0, 4'd0, D3, 1'b0, '0, 2'd0, 32'h0};     // tag 0
        v[14] = '{32'h100,  4'd0, 4'd5, D3, 1'b1, D3, 2'd0, 32'h0};
        v[15] = '{32'h100,  4'd0, 4'd0, '0, 1'b1, D3, 2'd0, 32'h0};
        v[16] = '{32'h200,  4'd1, 4'd0, '0, 1'b0, '0, 2'd1, 32'h200};   // redirect scenario
        v[17] = '{32'h308,  4'd0, 4'd0, '0, 1'b0, '0, 2'd0, 32'h0};
        v[18] = '{32'h100,  4'd0, 4'd0, '0, 1'b1, D3, 2'd0, 32'h0};     // hit while waiting
        v[19] = '{32'h308,  4'd0, 4'd1, D4, 1'b0, '0, 2'd0, 32'h0};     // fill, no forward
        v[20] = '{32'h308,  4'd0, 4'd0, '0, 1'b0, '0, 2'd1, 32'h308};
        v[21] = '{32'h204,  4'd0, 4'd0, '0, 1'b1, D4, 2'd0, 32'h0};
        v[22] = '{32'h308,  4'd6, 4'd0, '0, 1'b0, '0, 2'd1, 32'h308};
        v[23] = '{32'h204,  4'd0, 4'd6, D5, 1'b1, D4, 2'd0, 32'h0};     // hit + fill other line
        v[24] = '{32'h308,  4'd0, 4'd0, '0, 1'b1, D5, 2'd0, 32'h0};
        v[25] = '{32'h30C,  4'd0, 4'd6, D6, 1'b1, D5, 2'd0, 32'h0};     // return in IDLE ignored

        repeat (2) @(negedge clock);
        chk("reset_state", 1'b0, '0, 2'd0, 32'h0);
        reset = 1'b1;
        addr  = 32'h0;

        for (int i = 0; i < 26; i++) begin
            @(negedge clock);
            addr  = v[i].addr;
            resp  = v[i].resp;
            rtag  = v[i].rtag;
            rdata = v[i].rdata;
            #1;
            chk($sformatf("vec%0d", i), v[i].e_vld, v[i].e_data, v[i].e_cmd, v[i].e_maddr);
        end

        // Async reset while a miss is outstanding.
        @(negedge clock);
        addr = 32'h400; resp = 4'd7; rtag = 4'd0; rdata = '0;
        #1 chk("wait_entry", 1'b0, '0, 2'd1, 32'h400);
        @(negedge clock);
        addr = 32'h204; resp = 4'd0;
        #1 chk("pre_reset_hit", 1'b1, D4, 2'd0, 32'h0);
        #2 reset = 1'b0;
        #1 chk("async_reset", 1'b0, '0, 2'd0, 32'h0);
        @(negedge clock);
        reset = 1'b1; addr = 32'h400; rtag = 4'd7; rdata = D6;
        #1 chk("post_reset_return", 1'b0, '0, 2'd1, 32'h400);
        @(negedge clock);
        addr = 32'h204; rtag = 4'd0;
        #1 chk("post_reset_miss", 1'b0, '0, 2'd1, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
